// File: rtl/vx_dcr_launch_ctrl_pkg.sv
// vx_dcr_launch_ctrl_pkg: shared types and widths for the DCR launch controller
//   DCR_ADDR_W / DCR_DATA_W  default DCR address/data widths (stand-ins for the VX DCR defines)
//   RUN_W                    width of the run-cycle counter
//   launch_state_e           launch sequencer states
//   dcr_entry_t              one DCR table entry (addr, data)
package vx_dcr_launch_ctrl_pkg;
   localparam int DCR_ADDR_W = 12;
   localparam int DCR_DATA_W = 32;
   localparam int RUN_W      = 32;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SETTLE,
      WAIT_BUSY,
      RUN,
      DONE
   } launch_state_e;

   typedef struct packed {
      logic [DCR_ADDR_W-1:0] addr;
      logic [DCR_DATA_W-1:0] data;
   } dcr_entry_t;
endpackage

// File: rtl/vx_dcr_launch_ctrl_if.sv
// vx_dcr_launch_ctrl_if: host config/launch, wrapper DCR write and busy/status signals
//   cfg_wr_valid/idx/addr/data  host table write port
//   cfg_count, start            launch request and number of entries to play
//   idle, done, error, run_cycles  controller status
//   dcr_wr_valid/addr/data      DCR write port towards the wrapper
//   vx_busy                     wrapper busy status
//   master: the launch controller    slave: host register file and wrapper
interface vx_dcr_launch_ctrl_if
   import vx_dcr_launch_ctrl_pkg::*;
#(
   parameter int NUM_DCRS       = 8,
   parameter int DCR_ADDR_WIDTH = DCR_ADDR_W,
   parameter int DCR_DATA_WIDTH = DCR_DATA_W
);
   localparam int IW = NUM_DCRS > 1 ? $clog2(NUM_DCRS) : 1;
   localparam int CW = $clog2(NUM_DCRS + 1);

   logic                      cfg_wr_valid;
   logic [IW-1:0]             cfg_wr_idx;
   logic [DCR_ADDR_WIDTH-1:0] cfg_wr_addr;
   logic [DCR_DATA_WIDTH-1:0] cfg_wr_data;
   logic [CW-1:0]             cfg_count;
   logic                      start;
   logic                      idle;
   logic                      dcr_wr_valid;
   logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr;
   logic [DCR_DATA_WIDTH-1:0] dcr_wr_data;
   logic                      vx_busy;
   logic                      done;
   logic                      error;
   logic [RUN_W-1:0]          run_cycles;

   modport master (
      input  cfg_wr_valid, cfg_wr_idx, cfg_wr_addr, cfg_wr_data, cfg_count, start, vx_busy,
      output idle, dcr_wr_valid, dcr_wr_addr, dcr_wr_data, done, error, run_cycles
   );

   modport slave (
      output cfg_wr_valid, cfg_wr_idx, cfg_wr_addr, cfg_wr_data, cfg_count, start, vx_busy,
      input  idle, dcr_wr_valid, dcr_wr_addr, dcr_wr_data, done, error, run_cycles
   );
endinterface

// File: rtl/vx_dcr_launch_ctrl_sat_counter.sv
// vx_dcr_launch_ctrl_sat_counter: saturating up-counter with synchronous clear
//   clk, reset  clock, async active-high reset
//   clear_i     load zero (wins over inc_i)
//   inc_i       count up by one, holding at all-ones
//   value_o     registered count
module vx_dcr_launch_ctrl_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] value_o
);
   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else if (clear_i) cnt_q <= '0;
      else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + WIDTH'(1);

   assign value_o = cnt_q;
endmodule

// File: rtl/vx_dcr_launch_ctrl.sv
// vx_dcr_launch_ctrl: plays a DCR table onto the wrapper, then tracks busy rise/fall
//   clk, reset  clock, async active-high reset
//   bus         master side of vx_dcr_launch_ctrl_if: table writes and start from the host,
//               DCR writes to the wrapper, busy from the wrapper, idle/done/error/run_cycles status
module vx_dcr_launch_ctrl
   import vx_dcr_launch_ctrl_pkg::*;
#(
   parameter int NUM_DCRS       = 8,
   parameter int DCR_ADDR_WIDTH = DCR_ADDR_W,
   parameter int DCR_DATA_WIDTH = DCR_DATA_W,
   parameter int SETTLE_CYCLES  = 4,
   parameter int BUSY_TIMEOUT   = 1024
) (
   input logic                  clk,
   input logic                  reset,
   vx_dcr_launch_ctrl_if.master bus
);
   localparam int IW = NUM_DCRS > 1 ? $clog2(NUM_DCRS) : 1;
   localparam int CW = $clog2(NUM_DCRS + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = BUSY_TIMEOUT > 1 ? $clog2(BUSY_TIMEOUT) : 1;

   launch_state_e             state_q, state_d;
   dcr_entry_t                table_q [NUM_DCRS];
   logic [IW-1:0]             ptr_q, ptr_d;
   logic [CW-1:0]             n_q, n_d, n_in;
   logic [SW-1:0]             cnt_q, cnt_d;
   logic [TW-1:0]             tmo_q, tmo_d;
   logic                      valid_q, valid_d;
   logic [DCR_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DCR_DATA_WIDTH-1:0] data_q, data_d;
   logic                      done_q, done_d;
   logic                      error_q, error_d;
   logic                      idle_q, idle_d;
   logic                      clr, inc, last, tmo_last;
   logic [RUN_W-1:0]          run;

   assign n_in     = bus.cfg_count > CW'(NUM_DCRS) ? CW'(NUM_DCRS) : bus.cfg_count;
   assign last     = CW'(ptr_q) + CW'(1) == n_q;
   assign tmo_last = tmo_q == TW'(BUSY_TIMEOUT - 1);
   assign clr      = state_q == IDLE && bus.start;
   // a rise seen in WAIT_BUSY is the first busy cycle, so it counts like any RUN cycle
   assign inc      = bus.vx_busy && (state_q == WAIT_BUSY || state_q == RUN);

   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = !bus.start ? IDLE : n_in == '0 ? DONE : WRITE;
         WRITE:     state_d = last ? SETTLE : WRITE;
         SETTLE:    state_d = cnt_q == SW'(1) ? WAIT_BUSY : SETTLE;
         WAIT_BUSY: state_d = bus.vx_busy ? RUN : tmo_last ? DONE : WAIT_BUSY;
         RUN:       state_d = bus.vx_busy ? RUN : DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      n_d     = clr ? n_in : n_q;
      ptr_d   = clr ? '0 : state_q == WRITE ? ptr_q + IW'(1) : ptr_q;
      cnt_d   = state_q == WRITE ? SW'(SETTLE_CYCLES) : state_q == SETTLE ? cnt_q - SW'(1) : cnt_q;
      tmo_d   = state_q == SETTLE ? '0 : state_q == WAIT_BUSY ? tmo_q + TW'(1) : tmo_q;
      error_d = clr ? 1'b0 : error_q | (state_q == WAIT_BUSY && !bus.vx_busy && tmo_last);
      valid_d = state_q == WRITE;
      addr_d  = valid_d ? table_q[ptr_q].addr : addr_q;
      data_d  = valid_d ? table_q[ptr_q].data : data_q;
      // done trails the DONE state by one cycle so it lines up with the return to IDLE
      done_d  = state_q == DONE;
      idle_d  = state_d == IDLE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ptr_q   <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         ptr_q   <= ptr_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         error_q <= error_d;
         idle_q  <= idle_d;
      end

   // flops rather than RAM: the table must clear on reset
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < NUM_DCRS; i++) table_q[i] <= '0;
      end else if (bus.cfg_wr_valid && state_q == IDLE && 32'(bus.cfg_wr_idx) < NUM_DCRS) begin
         table_q[bus.cfg_wr_idx] <= dcr_entry_t'{addr: bus.cfg_wr_addr, data: bus.cfg_wr_data};
      end

   vx_dcr_launch_ctrl_sat_counter #(.WIDTH(RUN_W)) u_run (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clr),
      .inc_i   (inc),
      .value_o (run)
   );

   assign bus.idle         = idle_q;
   assign bus.dcr_wr_valid = valid_q;
   assign bus.dcr_wr_addr  = addr_q;
   assign bus.dcr_wr_data  = data_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.run_cycles   = run;
endmodule

// File: tb/tb_vx_dcr_launch_ctrl.sv
// tb_vx_dcr_launch_ctrl: directed and randomized launches checked against a timeline model
module tb_vx_dcr_launch_ctrl;
   localparam int N  = 8;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int ST = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [AW-1:0] m_addr [N];
   logic [DW-1:0] m_data [N];

   always #5 clk = ~clk;

   vx_dcr_launch_ctrl_if #(.NUM_DCRS(N), .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW)) bus ();

   vx_dcr_launch_ctrl #(
      .NUM_DCRS(N), .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW),
      .SETTLE_CYCLES(ST), .BUSY_TIMEOUT(TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_idle"}, bus.idle, 1'b1);
      chk({tag, "_valid"}, bus.dcr_wr_valid, 1'b0);
      chk({tag, "_addr"}, bus.dcr_wr_addr, '0);
      chk({tag, "_data"}, bus.dcr_wr_data, '0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_error"}, bus.error, 1'b0);
      chk({tag, "_run"}, bus.run_cycles, '0);
   endtask

   task automatic cfg(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      bus.cfg_wr_valid = 1'b1;
      bus.cfg_wr_idx   = 3'(idx);
      bus.cfg_wr_addr  = a;
      bus.cfg_wr_data  = d;
      m_addr[idx] = a;
      m_data[idx] = d;
      @(posedge clk); #1;
      bus.cfg_wr_valid = 1'b0;
   endtask

   // Cycle 0 carries start. Entries appear in cycles 2..n+1, WAIT_BUSY opens at cycle n+1+ST,
   // busy is high in cycles [s, s+len). Done follows busy falling by two cycles, or the
   // timeout window closing by one.
   task automatic launch(input int cnt, input int s_off, input int len, input bit junk,
                         input bit co_wr, input int force_at);
      int n, w, s, r, done_c, idx;
      logic [31:0] run_e;
      bit err_e, v;
      n = cnt < N ? cnt : N;
      w = 1 + n + ST;
      s = w + s_off;
      if (n == 0) begin
         done_c = 2; run_e = 0; err_e = 0;
      end else begin
         r = s > w ? s : w;
         if (r < s + len && r < w + TO) begin
            done_c = s + len + 2; run_e = 32'(s + len - r); err_e = 0;
         end else begin
            done_c = w + TO + 1; run_e = 0; err_e = 1;
         end
      end
      if (force_at >= 0) run_e = 32'hFFFF_FFFF;
      for (int c = 0; c <= done_c + 1; c++) begin
         @(posedge clk); #1;
         bus.start = c == 0 || (junk && c < done_c && $urandom_range(0, 3) == 0);
         bus.cfg_wr_valid = (c == 0 && co_wr) || (junk && c > 0 && c < done_c && $urandom_range(0, 3) == 0);
         bus.cfg_count = 4'(c == 0 ? cnt : int'($urandom_range(0, 15)));
         if (bus.cfg_wr_valid) begin
            idx = $urandom_range(0, N - 1);
            bus.cfg_wr_idx  = 3'(idx);
            bus.cfg_wr_addr = AW'($urandom);
            bus.cfg_wr_data = $urandom;
            if (c == 0) begin
               m_addr[idx] = bus.cfg_wr_addr;
               m_data[idx] = bus.cfg_wr_data;
            end
         end
         bus.vx_busy = c >= s && c < s + len;
         @(negedge clk);
         v = n > 0 && c >= 2 && c < 2 + n;
         chk("dcr_wr_valid", bus.dcr_wr_valid, v);
         if (v) begin
            chk("dcr_wr_addr", bus.dcr_wr_addr, m_addr[c-2]);
            chk("dcr_wr_data", bus.dcr_wr_data, m_data[c-2]);
         end
         chk("done", bus.done, c == done_c);
         if (c == 1) begin
            chk("idle_busy", bus.idle, 1'b0);
            chk("error_cleared", bus.error, 1'b0);
            chk("run_cleared", bus.run_cycles, '0);
         end
         if (c == done_c) begin
            chk("idle_end", bus.idle, 1'b1);
            chk("run_cycles", bus.run_cycles, run_e);
         end
         if (c >= done_c) chk("error", bus.error, err_e);
         if (force_at >= 0 && c == force_at) force dut.u_run.cnt_q = 32'hFFFF_FFF0;
         if (force_at >= 0 && c == force_at + 1) release dut.u_run.cnt_q;
         if (force_at >= 0 && c == force_at + 2) chk("run_after_force", bus.run_cycles, 32'hFFFF_FFF1);
      end
      bus.start = 1'b0;
      bus.cfg_wr_valid = 1'b0;
      bus.vx_busy = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cfg_wr_valid = 1'b0;
      bus.cfg_wr_idx   = '0;
      bus.cfg_wr_addr  = '0;
      bus.cfg_wr_data  = '0;
      bus.cfg_count    = '0;
      bus.start        = 1'b0;
      bus.vx_busy      = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_addr[i] = '0;
         m_data[i] = '0;
      end
      #12;
      chk_reset("por");
      @(negedge clk);
      reset = 1'b0;

      cfg(0, 12'h001, 32'h8000_0000);
      cfg(1, 12'h002, 32'h0000_0000);
      cfg(2, 12'h003, 32'h0000_0001);
      launch(3, 2, 50, 1'b0, 1'b0, -1);
      launch(0, 0, 3, 1'b0, 1'b0, -1);
      launch(2, 100000, 1, 1'b0, 1'b0, -1);
      launch(2, 0, 5, 1'b0, 1'b0, -1);

      for (int i = 0; i < N; i++) cfg(i, AW'($urandom), $urandom);
      launch(9, 1, 6, 1'b1, 1'b0, -1);
      launch(8, 0, 4, 1'b0, 1'b0, -1);

      for (int i = 0; i < 4; i++) cfg(i, AW'($urandom), $urandom);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.cfg_count = 4'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_reset_valid", bus.dcr_wr_valid, 1'b1);
      chk("pre_reset_addr", bus.dcr_wr_addr, m_addr[0]);
      #1 reset = 1'b1;
      #1 chk_reset("mid");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         chk("post_reset_valid", bus.dcr_wr_valid, 1'b0);
         chk("post_reset_idle", bus.idle, 1'b1);
      end
      for (int i = 0; i < N; i++) begin
         m_addr[i] = '0;
         m_data[i] = '0;
      end
      launch(2, 0, 3, 1'b0, 1'b0, -1);
      for (int i = 0; i < 4; i++) cfg(i, AW'($urandom), $urandom);
      launch(4, 0, 3, 1'b0, 1'b0, -1);

      launch(1, 0, 60, 1'b0, 1'b0, 20);

      repeat (20) begin
         if ($urandom_range(0, 1) == 1) cfg($urandom_range(0, N - 1), AW'($urandom), $urandom);
         launch($urandom_range(0, 15), int'($urandom_range(0, TO + 3)) - 2, $urandom_range(1, 12),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
